clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl_pkg.sv | 14 +
 rtl/clk_div_phase.sv | 32 +++
 rtl/clk_div_ctrl.sv | 100 ++++++++++
 tb/tb_clk_div_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the glitch-free clock divider controller.
// Holds the FSM state encoding and the guard counter width.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRE_GATE  = 2'd1,
        WAIT_EDGE = 2'd2,
        POST_GATE = 2'd3
    } state_t;

    localparam int GUARD_W = 4;

endpackage

// File: rtl/clk_div_phase.sv
// Phase mirror of the downstream divider's posedge counter.
// Uses the divider's own wrap rule so both counters stay lock-stepped.
module clk_div_phase #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         rst_low_in,
    input  logic [W-1:0] div,
    input  logic         load_zero,
    output logic [W-1:0] phase,
    output logic         boundary
);

    logic [31:0] last;
    logic        wrap;

    // div=0 makes last all-ones, so the counter free-runs like the divider
    assign last     = 32'(div) - 32'd1;
    assign wrap     = 32'(phase) >= last;
    assign boundary = (div <= W'(1)) || wrap;

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            phase <= '0;
        end else if (load_zero || wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divide-value change controller: gates the clock, swaps the divide
// value on a divider period boundary, then re-enables the clock.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int MAX_DIVIDER  = 10,
    parameter int GUARD_CYCLES = 2,
    parameter int RESET_DIV    = 1,
    localparam int W = $clog2(MAX_DIVIDER)
) (
    input  logic         clk_in,
    input  logic         rst_low_in,
    input  logic         req_valid_in,
    input  logic [W-1:0] req_div_in,
    output logic         req_ready_out,
    output logic [W-1:0] div_out,
    output logic         clk_en_out,
    output logic         busy_out,
    output logic         err_out
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);
    localparam logic [W-1:0]       RST_DIV    = W'(RESET_DIV);

    state_t             state;
    logic [GUARD_W-1:0] guard_cnt;
    logic [W-1:0]       pend_div;
    logic [W-1:0]       phase_cnt;
    logic               boundary;
    logic               load_zero;
    logic               hs;
    logic               bad_req;

    assign req_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign hs            = req_valid_in && req_ready_out;
    assign bad_req       = 32'(req_div_in) >= 32'(MAX_DIVIDER);
    assign load_zero     = (state == WAIT_EDGE) && boundary;

    clk_div_phase #(
        .W(W)
    ) u_phase (
        .clk_in     (clk_in),
        .rst_low_in (rst_low_in),
        .div        (div_out),
        .load_zero  (load_zero),
        .phase      (phase_cnt),
        .boundary   (boundary)
    );

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            state      <= IDLE;
            div_out    <= RST_DIV;
            pend_div   <= RST_DIV;
            guard_cnt  <= '0;
            clk_en_out <= 1'b1;
            err_out    <= 1'b0;
        end else begin
            err_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        if (bad_req) begin
                            err_out <= 1'b1;
                        end else if (req_div_in != div_out) begin
                            pend_div   <= req_div_in;
                            guard_cnt  <= GUARD_INIT;
                            clk_en_out <= 1'b0;
                            state      <= PRE_GATE;
                        end
                    end
                end
                PRE_GATE: begin
                    guard_cnt <= guard_cnt - GUARD_W'(1);
                    if (guard_cnt == GUARD_W'(1)) begin
                        state <= WAIT_EDGE;
                    end
                end
                WAIT_EDGE: begin
                    // swap only where the divider itself wraps to zero
                    if (boundary) begin
                        div_out   <= pend_div;
                        guard_cnt <= GUARD_INIT;
                        state     <= POST_GATE;
                    end
                end
                POST_GATE: begin
                    guard_cnt <= guard_cnt - GUARD_W'(1);
                    if (guard_cnt == GUARD_W'(1)) begin
                        clk_en_out <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl with a model of the downstream
// divider counter and a scoreboard of expected change results.
module tb_clk_div_ctrl;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_div = 4'd0;
    logic       ready;
    logic [3:0] div;
    logic       en;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    clk_div_ctrl dut (
        .clk_in        (clk),
        .rst_low_in    (rst_n),
        .req_valid_in  (req_valid),
        .req_div_in    (req_div),
        .req_ready_out (ready),
        .div_out       (div),
        .clk_en_out    (en),
        .busy_out      (busy),
        .err_out       (err)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] div;
        int         lat;
        logic       err;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       err;
        logic       chg;
        logic [3:0] div;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[11];
    logic [3:0] dcnt;
    logic [3:0] prev_div;
    logic [3:0] cur_div;

    // downstream divider counter driven by div_out
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= 4'd0;
        else if (32'(dcnt) >= 32'(div) - 32'd1) dcnt <= 4'd0;
        else dcnt <= dcnt + 4'd1;
    end

    // the divide value must never move while the clock is enabled
    always @(negedge clk) begin
        if (rst_n && div !== prev_div) begin
            total++;
            if (en !== 1'b0) begin
                bad++;
                $display("FAIL div_change_ungated: en=%0b required 0", en);
            end
        end
        prev_div = div;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nxt(logic [3:0] d, logic [3:0] p);
        return (32'(p) >= 32'(d) - 32'd1) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic int wait_cyc(logic [3:0] d, logic [3:0] p0);
        logic [3:0] p = p0;
        int w = 1;
        for (int i = 0; i < G + 1; i++) p = nxt(d, p);
        while (!(d <= 4'd1 || 32'(p) >= 32'(d) - 32'd1)) begin
            p = nxt(d, p);
            w++;
        end
        return w;
    endfunction

    task automatic apply(vec_t v);
        exp_t e;
        int n;
        int gate_bad;
        e.div = v.div;
        e.err = v.err;
        e.lat = v.chg ? 2 * G + wait_cyc(cur_div, dcnt) + 1 : 1;
        sb.push_back(e);
        req_valid = 1'b1;
        req_div = v.req;
        step;
        req_valid = 1'b0;
        n = 1;
        gate_bad = 0;
        check("err_pulse", err, v.err);
        check("busy_after_hs", busy, v.chg);
        check("en_after_hs", en, !v.chg);
        while (!ready && n < 64) begin
            if (en) gate_bad++;
            step;
            n++;
        end
        e = sb.pop_front();
        check("div", div, e.div);
        check("latency", n, e.lat);
        check("gate_low", gate_bad, 0);
        check("en_idle", en, 1);
        if (v.err) begin
            step;
            check("err_one_cycle", err, 0);
        end
        cur_div = v.div;
    endtask

    initial begin
        int n;
        int k;
        logic seen;
        exp_t e;

        vt[0]  = '{4'd4,  1'b0, 1'b1, 4'd4};
        vt[1]  = '{4'd12, 1'b1, 1'b0, 4'd4};
        vt[2]  = '{4'd4,  1'b0, 1'b0, 4'd4};
        vt[3]  = '{4'd5,  1'b0, 1'b1, 4'd5};
        vt[4]  = '{4'd5,  1'b0, 1'b0, 4'd5};
        vt[5]  = '{4'd10, 1'b1, 1'b0, 4'd5};
        vt[6]  = '{4'd6,  1'b0, 1'b1, 4'd6};
        vt[7]  = '{4'd0,  1'b0, 1'b1, 4'd0};
        vt[8]  = '{4'd2,  1'b0, 1'b1, 4'd2};
        vt[9]  = '{4'd3,  1'b0, 1'b1, 4'd3};
        vt[10] = '{4'd9,  1'b0, 1'b1, 4'd9};

        #12;
        check("rst_div", div, 1);
        check("rst_en", en, 1);
        check("rst_ready", ready, 1);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        cur_div = 4'd1;

        for (int i = 0; i <= 6; i++) apply(vt[i]);

        // 6 -> 3 with the divider counter at 1 on the handshake edge
        k = 0;
        while (dcnt != 4'd1 && k < 20) begin
            step;
            k++;
        end
        check("phase_sync", dcnt, 1);
        e.div = 4'd3;
        e.lat = 7;
        e.err = 1'b0;
        sb.push_back(e);
        req_valid = 1'b1;
        req_div = 4'd3;
        step;
        req_valid = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!ready && n < 64) begin
            if (div == 4'd3 && !seen) begin
                seen = 1'b1;
                check("chg_cycle", n, 5);
                check("div_cnt_zero", dcnt, 0);
                check("en_at_chg", en, 0);
            end
            step;
            n++;
        end
        check("chg_seen", seen, 1);
        e = sb.pop_front();
        check("div_6to3", div, e.div);
        check("lat_6to3", n, e.lat);
        cur_div = 4'd3;

        for (int i = 7; i <= 8; i++) apply(vt[i]);

        // reset in the middle of a 2 -> 7 change
        req_valid = 1'b1;
        req_div = 4'd7;
        step;
        req_valid = 1'b0;
        step;
        step;
        check("wait_busy", busy, 1);
        check("wait_en", en, 0);
        check("wait_div", div, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_div", div, 1);
        check("mid_rst_en", en, 1);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step;
        cur_div = 4'd1;

        for (int i = 9; i <= 10; i++) apply(vt[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
